// File: rtl/dl_pkg.sv
// Shared definitions for the HPS download controller: ioctl index codes,
// controller states and DIP byte pack/unpack helpers.
package dl_pkg;

   localparam logic [7:0] IDX_ROM = 8'd0;
   localparam logic [7:0] IDX_MOD = 8'd1;
   localparam logic [7:0] IDX_DIP = 8'd254;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } dl_state_e;

   function automatic logic [7:0] dip_byte(input logic [63:0] dip, input logic [2:0] k);
      return dip[8*k +: 8];
   endfunction

   function automatic logic [63:0] dip_set(input logic [63:0] dip, input logic [2:0] k,
                                           input logic [7:0] b);
      logic [63:0] r;
      r = dip;
      r[8*k +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/dl_byte_fifo.sv
// Small synchronous FIFO for {addr,data} ROM bytes. Pointers carry one extra
// wrap bit so full/empty fall out of the MSB comparison.
module dl_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 24,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [PW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [PW:0]  wr_ptr, rd_ptr;
   logic [W-1:0] mem [DEPTH];

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; a push into a full FIFO with a same-cycle pop
   // overwrites the head slot only after it has been read out this cycle.
   always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/dl_load_ctrl.sv
// HPS ioctl download sequencer: routes ROM/mod/DIP bytes, drains ROM bytes
// into idle ROM write slots and holds the core in reset around loads.
module dl_load_ctrl
   import dl_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int ROM_AW      = 16,
   parameter int HOLD_CYCLES = 1024
) (
   input  logic              clk_sys,
   input  logic              RESET_N,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   input  logic              user_reset,
   input  logic              slot_en,
   output logic [ROM_AW-1:0] rom_addr,
   output logic [7:0]        rom_data,
   output logic              rom_wr,
   output logic [7:0]        mod,
   output logic [63:0]       dip,
   output logic              core_reset,
   output logic              overflow
);

   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = PW + 1;
   localparam int EW   = ROM_AW + 8;
   localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLD_CYCLES - 1);

   dl_state_e       state_q, state_d;
   logic [HC_W-1:0] cnt_q, cnt_d;

   logic          rom_req, addr_ok, push, pop, drop;
   logic [EW-1:0] head;
   logic [CW-1:0] fifo_cnt, cnt_nx;
   logic          fifo_full, fifo_empty;

   assign addr_ok = ((ioctl_addr >> ROM_AW) == 25'd0);
   assign rom_req = ioctl_wr && (ioctl_index == IDX_ROM) && addr_ok;
   assign pop     = slot_en && !fifo_empty;
   assign push    = rom_req && (!fifo_full || pop);
   assign drop    = rom_req && fifo_full && !pop;
   assign cnt_nx  = fifo_cnt + CW'(push) - CW'(pop);

   dl_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
      .clk_sys   (clk_sys),
      .rst_n     (RESET_N),
      .push      (push),
      .push_data ({ioctl_addr[ROM_AW-1:0], ioctl_dout}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_cnt),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= HOLD;
         cnt_q   <= HOLD_INIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A user reset during LOAD/DRAIN is dropped: the post-load HOLD covers it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (ioctl_download && ioctl_index == IDX_ROM) begin
               state_d = LOAD;
            end else if (user_reset) begin
               state_d = HOLD;
               cnt_d   = HOLD_INIT;
            end
         end
         LOAD: begin
            if (!ioctl_download) state_d = DRAIN;
         end
         DRAIN: begin
            if (fifo_empty && !rom_wr) begin
               state_d = HOLD;
               cnt_d   = HOLD_INIT;
            end
         end
         HOLD: begin
            if (user_reset)        cnt_d   = HOLD_INIT;
            else if (cnt_q == '0)  state_d = RUN;
            else                   cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            state_d = HOLD;
            cnt_d   = HOLD_INIT;
         end
      endcase
   end

   assign core_reset = (state_q != RUN);

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         rom_wr     <= 1'b0;
         rom_addr   <= '0;
         rom_data   <= '0;
         ioctl_wait <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         rom_wr <= pop;
         if (pop) begin
            rom_addr <= head[EW-1:8];
            rom_data <= head[7:0];
         end
         // Raised one entry early so a write already in flight still fits.
         ioctl_wait <= (cnt_nx >= CW'(FIFO_DEPTH - 1));
         if (state_q == RUN && state_d == LOAD) overflow <= 1'b0;
         if (drop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         mod <= 8'h00;
         dip <= {64{1'b1}};
      end else if (ioctl_wr) begin
         if (ioctl_index == IDX_MOD) mod <= ioctl_dout;
         if (ioctl_index == IDX_DIP && ioctl_addr[24:3] == 22'd0)
            dip <= dip_set(dip, ioctl_addr[2:0], ioctl_dout);
      end
   end

endmodule

// File: tb/tb_dl_load_ctrl.sv
// Directed bench for dl_load_ctrl: reset hold, ROM loads with and without
// slot availability, DIP/mod capture, user reset timing and mid-load reset.
module tb_dl_load_ctrl;
   import dl_pkg::*;

   localparam int HC = 1024;

   logic        clk_sys = 1'b0;
   logic        RESET_N = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic        ioctl_wait;
   logic        user_reset = 1'b0;
   logic        slot_en = 1'b1;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_wr;
   logic [7:0]  mod;
   logic [63:0] dip;
   logic        core_reset;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] cap_addr [256];
   logic [7:0]  cap_data [256];
   int          cap_total = 0;

   dl_load_ctrl #(.FIFO_DEPTH(4), .ROM_AW(16), .HOLD_CYCLES(HC)) dut (
      .clk_sys        (clk_sys),
      .RESET_N        (RESET_N),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .user_reset     (user_reset),
      .slot_en        (slot_en),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .rom_wr         (rom_wr),
      .mod            (mod),
      .dip            (dip),
      .core_reset     (core_reset),
      .overflow       (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (RESET_N && rom_wr && cap_total < 256) begin
         cap_addr[cap_total] = rom_addr;
         cap_data[cap_total] = rom_data;
         cap_total = cap_total + 1;
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rom_write(input logic [24:0] a, input logic [7:0] d);
      ioctl_index = IDX_ROM;
      ioctl_addr  = a;
      ioctl_dout  = d;
      ioctl_wr    = 1'b1;
      tick();
      ioctl_wr    = 1'b0;
   endtask

   task automatic wait_run(output int n);
      n = 0;
      while (core_reset && n < 3000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int base;
      logic [63:0] dip_exp;

      // reset state
      repeat (3) tick();
      chk("rst_core_reset", core_reset, 1);
      chk("rst_rom_wr", rom_wr, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rom_data", rom_data, 0);
      chk("rst_wait", ioctl_wait, 0);
      chk("rst_mod", mod, 0);
      chk("rst_dip", dip, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_overflow", overflow, 0);

      RESET_N = 1'b1;
      wait_run(n);
      chk("hold_after_reset_cycles", n, HC);
      chk("run_core_reset", core_reset, 0);

      // 16-byte load with free slots
      base = cap_total;
      ioctl_download = 1'b1;
      ioctl_index    = IDX_ROM;
      tick();
      chk("load_core_reset", core_reset, 1);
      rom_write(25'd0, 8'hA5);
      chk("first_byte_not_yet", rom_wr, 0);
      tick();
      chk("first_byte_rom_wr", rom_wr, 1);
      chk("first_byte_addr", rom_addr, 0);
      chk("first_byte_data", rom_data, 8'hA5);
      for (int i = 1; i < 16; i++) begin
         rom_write(25'(i), 8'(i) ^ 8'hA5);
         tick();
      end
      chk("load16_wait", ioctl_wait, 0);
      ioctl_download = 1'b0;
      wait_run(n);
      chk("load16_count", cap_total - base, 16);
      for (int i = 0; i < 16; i++) begin
         chk("load16_addr", cap_addr[base+i], i);
         chk("load16_data", cap_data[base+i], 8'(i) ^ 8'hA5);
      end
      chk("load16_overflow", overflow, 0);

      // load with no slots: backpressure then drop
      base    = cap_total;
      slot_en = 1'b0;
      ioctl_download = 1'b1;
      tick();
      rom_write(25'd0, 8'h30); chk("bp_wait_c1", ioctl_wait, 0); tick();
      rom_write(25'd1, 8'h31); chk("bp_wait_c2", ioctl_wait, 0); tick();
      rom_write(25'd2, 8'h32); chk("bp_wait_c3", ioctl_wait, 1); tick();
      rom_write(25'd3, 8'h33); chk("bp_wait_c4", ioctl_wait, 1);
      chk("bp_overflow_full", overflow, 0);
      tick();
      rom_write(25'd4, 8'h34);
      chk("bp_overflow_drop", overflow, 1);
      chk("bp_no_drain", cap_total - base, 0);
      slot_en = 1'b1;
      ioctl_download = 1'b0;
      wait_run(n);
      chk("bp_drain_count", cap_total - base, 4);
      for (int i = 0; i < 4; i++) begin
         chk("bp_drain_addr", cap_addr[base+i], i);
         chk("bp_drain_data", cap_data[base+i], 8'h30 + 8'(i));
      end
      chk("bp_overflow_sticky", overflow, 1);
      chk("bp_wait_clear", ioctl_wait, 0);

      // DIP bytes, with download high on a non-ROM index
      ioctl_download = 1'b1;
      ioctl_index    = IDX_DIP;
      dip_exp        = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 8; k++) begin
         ioctl_addr = 25'(k);
         ioctl_dout = 8'h10 + 8'(k);
         ioctl_wr   = 1'b1;
         tick();
         ioctl_wr   = 1'b0;
         dip_exp[8*k +: 8] = 8'h10 + 8'(k);
         if (k == 0) chk("dip_first_byte", dip, 64'hFFFF_FFFF_FFFF_FF10);
         tick();
      end
      ioctl_addr = 25'd8;
      ioctl_dout = 8'h99;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
      tick();
      chk("dip_all", dip, 64'h1716_1514_1312_1110);
      chk("dip_model", dip, dip_exp);
      chk("dip_byte7", dip_byte(dip, 3'd7), 8'h17);
      chk("dip_core_reset", core_reset, 0);
      ioctl_download = 1'b0;

      // mod byte
      chk("mod_before", mod, 0);
      ioctl_index = IDX_MOD;
      ioctl_addr  = 25'h1234;
      ioctl_dout  = 8'h09;
      ioctl_wr    = 1'b1;
      tick();
      ioctl_wr    = 1'b0;
      chk("mod_after", mod, 8'h09);
      chk("mod_core_reset", core_reset, 0);

      // user reset during LOAD ignored; second one 10 cycles into HOLD restarts
      base = cap_total;
      ioctl_download = 1'b1;
      ioctl_index    = IDX_ROM;
      tick();
      chk("ur_overflow_cleared", overflow, 0);
      rom_write(25'd40, 8'h5A);
      user_reset = 1'b1;
      tick();
      user_reset = 1'b0;
      rom_write(25'd41, 8'h5B);
      repeat (20) tick();
      chk("ur_load_core_reset", core_reset, 1);
      ioctl_download = 1'b0;
      n = 0;
      while (core_reset && n < 3000) begin
         tick();
         n++;
         if (n == 12) user_reset = 1'b1;
         if (n == 13) user_reset = 1'b0;
      end
      chk("ur_hold_cycles", n, 1037);
      chk("ur_drain_count", cap_total - base, 2);
      chk("ur_drain_addr", cap_addr[base+1], 41);

      // RESET_N mid-load flushes the FIFO
      base    = cap_total;
      slot_en = 1'b0;
      ioctl_download = 1'b1;
      tick();
      rom_write(25'd0, 8'hC0); tick();
      rom_write(25'd1, 8'hC1); tick();
      rom_write(25'd2, 8'hC2); tick();
      chk("mid_wait_before", ioctl_wait, 1);
      RESET_N = 1'b0;
      #1;
      chk("mid_rom_wr", rom_wr, 0);
      chk("mid_wait", ioctl_wait, 0);
      chk("mid_core_reset", core_reset, 1);
      chk("mid_mod", mod, 0);
      ioctl_download = 1'b0;
      slot_en = 1'b1;
      tick();
      RESET_N = 1'b1;
      repeat (10) tick();
      chk("mid_fifo_empty", cap_total - base, 0);
      chk("mid_rom_wr_idle", rom_wr, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
